// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and encodings for the forwarding scoreboard.
// Stage entries carry a fixed-width address field; narrower register files zero-extend into it.
package fwd_scoreboard_pkg;

  localparam int SB_ADDR_MAX_W  = 16;
  localparam int FWD_REGFILE    = 0;
  localparam int FWD_STAGE_BASE = 1;

  typedef struct packed {
    logic                     valid;
    logic [SB_ADDR_MAX_W-1:0] addr;
    logic                     is_load;
  } sb_entry_t;

  // Width of a forward select able to encode "register file" plus n stage indices.
  function automatic int sel_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Decode-side issue bundle and the forwarding/stall results returned to it.
interface fwd_scoreboard_if #(
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int SEL_W    = 2
);
  logic                       issue_valid;
  logic                       issue_reg_write_enable;
  logic [ADDR_W-1:0]          issue_reg_write_addr;
  logic                       issue_is_load;
  logic [NUM_READ*ADDR_W-1:0] issue_read_addr;
  logic [NUM_READ-1:0]        issue_read_use;
  logic [NUM_READ*SEL_W-1:0]  forward_sel;
  logic                       stall_flag;

  modport master (
    output issue_valid, issue_reg_write_enable, issue_reg_write_addr,
           issue_is_load, issue_read_addr, issue_read_use,
    input  forward_sel, stall_flag
  );

  modport slave (
    input  issue_valid, issue_reg_write_enable, issue_reg_write_addr,
           issue_is_load, issue_read_addr, issue_read_use,
    output forward_sel, stall_flag
  );
endinterface

// File: rtl/fwd_scoreboard_sat_counter.sv
// Saturating event counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// Data-hazard scoreboard: tracks in-flight writers, picks the youngest forwarding source
// per read port, detects load-use hazards and applies branch flushes to the younger stages.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int ADDR_W           = 5,
  parameter int NUM_READ         = 2,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int FLUSH_DEPTH      = 2,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  fwd_scoreboard_if.slave  sb_if,
  input  logic             flush_i,
  input  logic             cnt_clear_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] fwd_cnt_o
);

  localparam int SEL_W = sel_width(NUM_STAGES);

  sb_entry_t                 stage_q [NUM_STAGES];
  sb_entry_t                 stage_d [NUM_STAGES];
  logic [NUM_READ-1:0]       load_hit;
  logic [NUM_READ*SEL_W-1:0] sel_raw;
  logic                      hazard;
  logic                      stall;
  logic                      capture;
  logic                      fwd_inc;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [ADDR_W-1:0]     rd_addr;
    logic [NUM_STAGES-1:0] hit;
    logic [SEL_W-1:0]      sel;
    logic                  lh;

    assign rd_addr = sb_if.issue_read_addr[p*ADDR_W +: ADDR_W];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      assign hit[i] = sb_if.issue_valid && sb_if.issue_read_use[p] &&
                      stage_q[i].valid && (rd_addr != '0) &&
                      (stage_q[i].addr == SB_ADDR_MAX_W'(rd_addr));
    end

    // Scan oldest to youngest so the lowest matching stage is the one that sticks.
    always_comb begin
      sel = SEL_W'(FWD_REGFILE);
      lh  = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (hit[i]) begin
          sel = SEL_W'(FWD_STAGE_BASE + i);
          lh  = stage_q[i].is_load && (i < LOAD_READY_STAGE);
        end
      end
    end

    assign load_hit[p]                 = lh;
    assign sel_raw[p*SEL_W +: SEL_W]   = sel;
  end

  assign hazard  = |load_hit;
  assign stall   = hazard && !flush_i;
  assign capture = sb_if.issue_valid && !stall && !flush_i;
  assign fwd_inc = capture && (|sel_raw);

  assign sb_if.stall_flag  = stall;
  assign sb_if.forward_sel = stall ? '0 : sel_raw;

  // NOTE: every stage_d element is given a default before any condition, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_d[i] = '0;
    end
    if (capture && sb_if.issue_reg_write_enable && (sb_if.issue_reg_write_addr != '0)) begin
      stage_d[0].valid   = 1'b1;
      stage_d[0].addr    = SB_ADDR_MAX_W'(sb_if.issue_reg_write_addr);
      stage_d[0].is_load = sb_if.issue_is_load;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (flush_i) begin
      for (int i = 0; (i < FLUSH_DEPTH) && (i < NUM_STAGES); i++) begin
        stage_d[i] = '0;
      end
    end
  end

  // NOTE: the stage array is a handful of flops, not a RAM, so it is reset to drop in-flight writers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall),
    .clear_i (cnt_clear_i),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fwd_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (fwd_inc),
    .clear_i (cnt_clear_i),
    .count_o (fwd_cnt_o)
  );

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus random issue streams against an age-list model.
// A second instance with 4-bit counters shares the stimulus to exercise saturation quickly.
module tb_fwd_scoreboard;

  localparam int NUM_STAGES = 3;
  localparam int LOAD_READY = 1;
  localparam int FLUSH_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        cnt_clear;
  logic [15:0] stall_cnt;
  logic [15:0] fwd_cnt;
  logic [3:0]  sat_stall_cnt;
  logic [3:0]  sat_fwd_cnt;
  logic [1:0]  sel0;
  logic [1:0]  sel1;

  int total = 0;
  int bad   = 0;

  fwd_scoreboard_if #(.ADDR_W(5), .NUM_READ(2), .SEL_W(2)) sb_if ();
  fwd_scoreboard_if #(.ADDR_W(5), .NUM_READ(2), .SEL_W(2)) sat_if ();

  fwd_scoreboard #(
    .ADDR_W(5), .NUM_READ(2), .NUM_STAGES(NUM_STAGES), .LOAD_READY_STAGE(LOAD_READY),
    .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .sb_if(sb_if), .flush_i(flush), .cnt_clear_i(cnt_clear),
    .stall_cnt_o(stall_cnt), .fwd_cnt_o(fwd_cnt)
  );

  fwd_scoreboard #(
    .ADDR_W(5), .NUM_READ(2), .NUM_STAGES(NUM_STAGES), .LOAD_READY_STAGE(LOAD_READY),
    .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst(rst), .sb_if(sat_if), .flush_i(flush), .cnt_clear_i(cnt_clear),
    .stall_cnt_o(sat_stall_cnt), .fwd_cnt_o(sat_fwd_cnt)
  );

  assign sat_if.issue_valid            = sb_if.issue_valid;
  assign sat_if.issue_reg_write_enable = sb_if.issue_reg_write_enable;
  assign sat_if.issue_reg_write_addr   = sb_if.issue_reg_write_addr;
  assign sat_if.issue_is_load          = sb_if.issue_is_load;
  assign sat_if.issue_read_addr        = sb_if.issue_read_addr;
  assign sat_if.issue_read_use         = sb_if.issue_read_use;

  assign sel0 = sb_if.forward_sel[1:0];
  assign sel1 = sb_if.forward_sel[3:2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: list of in-flight writers with their age ----------------
  typedef struct {
    int addr;
    bit is_load;
    int age;
  } m_ent_t;

  m_ent_t mq[$];
  bit     in_v, in_we, in_ld, in_flush, in_clr;
  int     in_wa;
  int     in_ra[2];
  bit [1:0] in_use;
  int     exp_sel[2];
  bit     exp_stall, exp_any;
  int     m_stall, m_fwd, m_sat_stall, m_sat_fwd;

  function automatic void model_eval();
    bit hz;
    int best;
    int raw[2];
    hz = 1'b0;
    for (int p = 0; p < 2; p++) begin
      raw[p] = 0;
      if (in_v && in_use[p] && in_ra[p] != 0) begin
        best = -1;
        foreach (mq[k]) begin
          if (mq[k].addr == in_ra[p] && (best < 0 || mq[k].age < mq[best].age)) best = k;
        end
        if (best >= 0) begin
          raw[p] = mq[best].age + 1;
          if (mq[best].is_load && mq[best].age < LOAD_READY) hz = 1'b1;
        end
      end
    end
    exp_stall = hz && !in_flush;
    exp_any   = (raw[0] != 0) || (raw[1] != 0);
    for (int p = 0; p < 2; p++) exp_sel[p] = exp_stall ? 0 : raw[p];
  endfunction

  function automatic void model_commit();
    bit cap;
    m_ent_t nq[$];
    m_ent_t e;
    cap = in_v && !exp_stall && !in_flush;
    if (in_clr) begin
      m_stall = 0; m_fwd = 0; m_sat_stall = 0; m_sat_fwd = 0;
    end else begin
      if (exp_stall) begin
        if (m_stall < 65535) m_stall++;
        if (m_sat_stall < 15) m_sat_stall++;
      end
      if (cap && exp_any) begin
        if (m_fwd < 65535) m_fwd++;
        if (m_sat_fwd < 15) m_sat_fwd++;
      end
    end
    foreach (mq[k]) begin
      e = mq[k];
      e.age++;
      if (e.age < NUM_STAGES && !(in_flush && e.age < FLUSH_DEPTH)) nq.push_back(e);
    end
    if (cap && in_we && in_wa != 0) begin
      e.addr = in_wa; e.is_load = in_ld; e.age = 0;
      nq.push_back(e);
    end
    mq = nq;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input bit we, input int wa, input bit ld,
                       input int ra0, input int ra1, input bit [1:0] use_bits,
                       input bit fl, input bit clr);
    in_v = v; in_we = we; in_wa = wa; in_ld = ld;
    in_ra[0] = ra0; in_ra[1] = ra1; in_use = use_bits; in_flush = fl; in_clr = clr;
    sb_if.issue_valid            = v;
    sb_if.issue_reg_write_enable = we;
    sb_if.issue_reg_write_addr   = 5'(wa);
    sb_if.issue_is_load          = ld;
    sb_if.issue_read_addr        = {5'(ra1), 5'(ra0)};
    sb_if.issue_read_use         = use_bits;
    flush                        = fl;
    cnt_clear                    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1, 1, 5, 0, 5, 5, 2'b11, 0, 0);
    rst = 1'b1;
    #1;
    total++; if (sb_if.stall_flag !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", sb_if.stall_flag); end
    total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL reset_sel0 got=%0d want=0", sel0); end
    total++; if (sel1 !== 2'd0) begin bad++; $display("FAIL reset_sel1 got=%0d want=0", sel1); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (fwd_cnt !== 16'd0) begin bad++; $display("FAIL reset_fwd_cnt got=%0d want=0", fwd_cnt); end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_forward();
    do_reset();
    drive(1, 1, 5, 0, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 5, 0, 2'b01, 0, 0);
    @(negedge clk);
    total++; if (sel0 !== 2'd1) begin bad++; $display("FAIL alu_sel0 got=%0d want=1", sel0); end
    total++; if (sel1 !== 2'd0) begin bad++; $display("FAIL alu_sel1 got=%0d want=0", sel1); end
    total++; if (sb_if.stall_flag !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b want=0", sb_if.stall_flag); end
    tick();
    total++; if (fwd_cnt !== 16'd1) begin bad++; $display("FAIL alu_fwd_cnt got=%0d want=1", fwd_cnt); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL alu_stall_cnt got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 7, 1, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 7, 2'b10, 0, 0);
    @(negedge clk);
    total++; if (sb_if.stall_flag !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", sb_if.stall_flag); end
    total++; if (sel1 !== 2'd0) begin bad++; $display("FAIL lu_sel1_forced got=%0d want=0", sel1); end
    tick();
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=1", stall_cnt); end
    @(negedge clk);
    total++; if (sb_if.stall_flag !== 1'b0) begin bad++; $display("FAIL lu_stall_clear got=%0b want=0", sb_if.stall_flag); end
    total++; if (sel1 !== 2'd2) begin bad++; $display("FAIL lu_sel1 got=%0d want=2", sel1); end
    tick();
    total++; if (fwd_cnt !== 16'd1) begin bad++; $display("FAIL lu_fwd_cnt got=%0d want=1", fwd_cnt); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt_hold got=%0d want=1", stall_cnt); end
  endtask

  task automatic test_priority_x0();
    do_reset();
    drive(1, 1, 9, 0, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 1, 9, 0, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 9, 9, 2'b11, 0, 0);
    @(negedge clk);
    total++; if (sel0 !== 2'd1) begin bad++; $display("FAIL prio_sel0 got=%0d want=1", sel0); end
    total++; if (sel1 !== 2'd1) begin bad++; $display("FAIL prio_sel1 got=%0d want=1", sel1); end
    #1;
    drive(1, 0, 0, 0, 9, 9, 2'b01, 0, 0);
    #1;
    total++; if (sel1 !== 2'd0) begin bad++; $display("FAIL unused_port_sel1 got=%0d want=0", sel1); end
    drive(0, 0, 0, 0, 9, 9, 2'b11, 0, 0);
    #1;
    total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL no_issue_sel0 got=%0d want=0", sel0); end
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 2'b11, 0, 0);
    @(negedge clk);
    total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL x0_sel0 got=%0d want=0", sel0); end
    total++; if (sb_if.stall_flag !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b want=0", sb_if.stall_flag); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 2, 0, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 1, 4, 0, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 1, 3, 0, 0, 0, 2'b00, 1, 0);
    tick();
    drive(1, 0, 0, 0, 4, 2, 2'b11, 0, 0);
    @(negedge clk);
    total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL flush_x4_sel got=%0d want=0", sel0); end
    total++; if (sel1 !== 2'd3) begin bad++; $display("FAIL flush_wb_sel got=%0d want=3", sel1); end
    tick();
    total++; if (fwd_cnt !== 16'd1) begin bad++; $display("FAIL flush_fwd_cnt got=%0d want=1", fwd_cnt); end
    drive(1, 0, 0, 0, 3, 0, 2'b01, 0, 0);
    @(negedge clk);
    total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL flush_x3_sel got=%0d want=0", sel0); end
    do_reset();
    drive(1, 1, 7, 1, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 7, 0, 2'b01, 1, 0);
    @(negedge clk);
    total++; if (sb_if.stall_flag !== 1'b0) begin bad++; $display("FAIL flush_over_stall got=%0b want=0", sb_if.stall_flag); end
    total++; if (sel0 !== 2'd1) begin bad++; $display("FAIL flush_raw_sel got=%0d want=1", sel0); end
    tick();
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL flush_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (fwd_cnt !== 16'd0) begin bad++; $display("FAIL flush_no_fwd_cnt got=%0d want=0", fwd_cnt); end
    drive(1, 0, 0, 0, 7, 0, 2'b01, 0, 0);
    @(negedge clk);
    total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL flush_killed_load got=%0d want=0", sel0); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 7, 1, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 7, 2'b10, 0, 0);
    tick();
    tick();
    drive(1, 1, 7, 1, 0, 0, 2'b00, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 7, 2'b10, 0, 0);
    @(negedge clk);
    total++; if (sb_if.stall_flag !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%0b want=1", sb_if.stall_flag); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL mid_pre_cnt got=%0d want=1", stall_cnt); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (sb_if.stall_flag !== 1'b0) begin bad++; $display("FAIL mid_rst_stall got=%0b want=0", sb_if.stall_flag); end
    total++; if (sel1 !== 2'd0) begin bad++; $display("FAIL mid_rst_sel1 got=%0d want=0", sel1); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (fwd_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_fwd_cnt got=%0d want=0", fwd_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    // lw x7,0(x7) repeated: each capture is followed by one load-use stall.
    drive(1, 1, 7, 1, 7, 0, 2'b01, 0, 0);
    repeat (40) tick();
    total++; if (stall_cnt !== 16'd20) begin bad++; $display("FAIL sat_main_stall got=%0d want=20", stall_cnt); end
    total++; if (fwd_cnt !== 16'd19) begin bad++; $display("FAIL sat_main_fwd got=%0d want=19", fwd_cnt); end
    total++; if (sat_stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_stall got=%0d want=15", sat_stall_cnt); end
    total++; if (sat_fwd_cnt !== 4'hF) begin bad++; $display("FAIL sat_fwd got=%0d want=15", sat_fwd_cnt); end
    drive(1, 1, 7, 1, 7, 0, 2'b01, 0, 1);
    tick();
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL clr_main_stall got=%0d want=0", stall_cnt); end
    total++; if (fwd_cnt !== 16'd0) begin bad++; $display("FAIL clr_main_fwd got=%0d want=0", fwd_cnt); end
    total++; if (sat_stall_cnt !== 4'd0) begin bad++; $display("FAIL clr_sat_stall got=%0d want=0", sat_stall_cnt); end
    total++; if (sat_fwd_cnt !== 4'd0) begin bad++; $display("FAIL clr_sat_fwd got=%0d want=0", sat_fwd_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    mq.delete();
    m_stall = 0; m_fwd = 0; m_sat_stall = 0; m_sat_fwd = 0;
    for (int n = 0; n < 800; n++) begin
      drive(($urandom % 4) != 0, $urandom % 2, $urandom % 6, ($urandom % 3) == 0,
            $urandom % 6, $urandom % 6, 2'($urandom), ($urandom % 10) == 0,
            ($urandom % 60) == 0);
      @(negedge clk);
      model_eval();
      total++; if (int'(sel0) != exp_sel[0]) begin bad++; $display("FAIL rnd_sel0 cyc=%0d got=%0d want=%0d", n, sel0, exp_sel[0]); end
      total++; if (int'(sel1) != exp_sel[1]) begin bad++; $display("FAIL rnd_sel1 cyc=%0d got=%0d want=%0d", n, sel1, exp_sel[1]); end
      total++; if (sb_if.stall_flag !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0b want=%0b", n, sb_if.stall_flag, exp_stall); end
      tick();
      model_commit();
      total++; if (int'(stall_cnt) != m_stall) begin bad++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d want=%0d", n, stall_cnt, m_stall); end
      total++; if (int'(fwd_cnt) != m_fwd) begin bad++; $display("FAIL rnd_fwd_cnt cyc=%0d got=%0d want=%0d", n, fwd_cnt, m_fwd); end
      total++; if (int'(sat_stall_cnt) != m_sat_stall) begin bad++; $display("FAIL rnd_sat_stall cyc=%0d got=%0d want=%0d", n, sat_stall_cnt, m_sat_stall); end
      total++; if (int'(sat_fwd_cnt) != m_sat_fwd) begin bad++; $display("FAIL rnd_sat_fwd cyc=%0d got=%0d want=%0d", n, sat_fwd_cnt, m_sat_fwd); end
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_priority_x0();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the fixed two-port, three-stage data-hazard controller.
- Tracks in-flight register writes across NUM_STAGES post-decode pipeline stages in an internal shift register.
- Produces per-read-port forwarding selects for NUM_READ operands, a generalised load-use stall and a branch flush of the younger stages.
- Keeps saturating stall and forward statistics counters.
- Sits beside the ID/EX pipeline register. It is fed by decode and drives the ALU-input forwarding muxes.

Parameters:
ADDR_W, 5, register-address width
NUM_READ, 2, operand read ports checked per issued instruction
NUM_STAGES, 3, tracked stages after issue (index 0=EX, 1=MEM, 2=WB)
LOAD_READY_STAGE, 1, lowest stage index from which a load result can be forwarded
FLUSH_DEPTH, 2, stages invalidated by a flush (1..NUM_STAGES)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
issue_valid  in  1  decoded instruction presented this cycle
issue_reg_write_enable  in  1  instruction writes a register
issue_reg_write_addr  in  ADDR_W  destination register
issue_is_load  in  1  result comes from data memory (reg_write_select=1)
issue_read_addr  in  NUM_READ*ADDR_W  source registers, port p at [p*ADDR_W +: ADDR_W]
issue_read_use  in  NUM_READ  port p actually reads its operand
flush  in  1  branch taken; kill younger stages
cnt_clear  in  1  synchronous clear of both counters
forward_sel  out  NUM_READ*SEL_W  per port: 0=register file, k=stage k-1 result; SEL_W=$clog2(NUM_STAGES+1)
stall_flag  out  1  hold IF/ID and insert a bubble
stall_cnt  out  CNT_W  cycles stalled, saturating
fwd_cnt  out  CNT_W  issued instructions with at least one forwarded operand, saturating

Behaviour:
- Reset and interface timing:
  - Clock is clk. Reset rst is asynchronous, active-high.
  - On reset, all stage entries are invalid and both counters are 0.
  - With entries invalid, stall_flag=0 and forward_sel=0.
  - Reset mid-operation drops every in-flight entry immediately.
- Stage entry:
  - Each entry is {valid, addr, is_load}.
  - An entry is valid only if issue_valid and issue_reg_write_enable were both set and addr≠0.
  - Register x0 never matches.
- Outputs are combinational from the current entries and the issue inputs, with zero latency.
- Match rule: port p matches stage i when all of the following hold:
  - issue_valid and issue_read_use[p] are 1;
  - stage i is valid;
  - stage i addr equals read addr p;
  - read addr p is not 0.
- Forward select:
  - forward_sel[p] = 1 + the lowest matching i, so the youngest writer wins.
  - With no match, forward_sel[p] = 0.
- Load-use hazard: for any port, the youngest match is a load with i < LOAD_READY_STAGE.
- stall_flag = hazard AND NOT flush.
- While stall_flag=1, all forward_sel are forced to 0.
- On each posedge, entries shift: stage[i] <= stage[i-1] for i≥1.
- stage[0] loads as follows:
  - it receives the issue entry when issue_valid and NOT stall_flag and NOT flush;
  - otherwise it receives a bubble (invalid).
- The oldest stage falls off the end.
- Stall behaviour:
  - The stalled instruction is re-presented by upstream with unchanged inputs.
  - The hazard clears once the load reaches LOAD_READY_STAGE.
  - With defaults this gives exactly one stall cycle.
- Flush:
  - Post-shift stages 0..FLUSH_DEPTH-1 are invalid.
  - Older entries shift normally.
  - Flush overrides stall.
  - Flush with issue_valid is not captured.
- Counters:
  - stall_cnt increments each cycle stall_flag=1.
  - fwd_cnt increments each cycle an unstalled, unflushed issue has any forward_sel≠0.
  - Both saturate at all-ones.
  - cnt_clear has priority over increment.
- NUM_STAGES=1 is legal. If LOAD_READY_STAGE ≥ NUM_STAGES, loads are never forwarded and the consumer stalls until the load leaves the scoreboard.

Decomposition:
- Shared package holds:
  - typedef sb_entry_t {valid, addr, is_load};
  - the forward-select encoding constants FWD_REGFILE=0 and FWD_STAGE_BASE=1;
  - function sel_width(n).
- One natural sub-module: sat_counter (CNT_W, inc, clear), instantiated twice.
- Match/priority logic stays in a generate loop in the top.

Test Plan:
- ALU forward: cycle 0 issue add x5 (write, not load); cycle 1 issue reads x5 on port 0 → forward_sel[0]=1, stall_flag=0, fwd_cnt=1 after the edge.
- Load-use: cycle 0 load x7; cycle 1 read x7 port 1 → stall_flag=1 for one cycle, stall_cnt=1; cycle 2 same issue → forward_sel[1]=2, stall_flag=0.
- Priority and x0:
  - two back-to-back writes to x9 then read x9 → sel=1 (youngest);
  - a write to x0 followed by a read of x0 → sel=0, no stall.
- Flush: writes to x3, x4 in flight; flush asserted → next cycle reads of x3/x4 give sel=0, and older entries still forward (sel=3 for the WB entry).
- Reset mid-stall: assert rst during stall_flag=1 → stall_flag=0, all sel=0, counters 0 asynchronously.
- Saturation: force 2^CNT_W+3 stall cycles → stall_cnt=all-ones; then cnt_clear → 0 next edge.
